pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the datapath payload (operands, ALU result, PC).
REQ-002 The block SHALL have parameter CTRL_W, default 8, giving the width of the control payload (RegWrite, MemRead, PCsrc, etc.).
REQ-003 The block SHALL have port clock, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all held entries (branch mispredict or exception).
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream stage offers an entry.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept an entry this cycle.
REQ-008 The block SHALL have port in_ctrl, input, CTRL_W bits: control payload.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: data payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: head entry presented downstream.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the head entry.
REQ-012 The block SHALL have port out_ctrl, output, CTRL_W bits: head control payload.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: head data payload.
REQ-014 The block SHALL have port occupancy, output, 2 bits: number of held entries (0..2).

Function
REQ-015 A transfer SHALL occur on a rising edge where the valid and ready of the same side are both 1; no other condition SHALL move an entry.
REQ-016 The block SHALL hold entries in FIFO order, with states EMPTY (occupancy 0), ONE (occupancy 1) and TWO (occupancy 2, TWO only when PIPE_SKID_EN is defined).
REQ-017 The state transitions SHALL be as follows:
- EMPTY: an input transfer SHALL go to ONE.
- ONE: input only SHALL go to TWO (with PIPE_SKID_EN) or is impossible (without it); output only SHALL go to EMPTY; both SHALL stay in ONE with the new entry at head.
- TWO: output only SHALL go to ONE, with the second entry promoted to head.
REQ-018 The latency from in_valid to out_valid SHALL be exactly 1 cycle, and there SHALL be no combinational path from in_valid, in_ctrl or in_data to any output.
REQ-019 out_valid SHALL equal (occupancy != 0).
REQ-020 While out_valid=0, out_ctrl SHALL be all zeros (bubble, so no RegWrite or MemWrite leaks), and out_data SHALL hold its last value.
REQ-021 While out_valid=1 and out_ready=0, out_ctrl and out_data SHALL remain stable until the output transfer.
REQ-022 flush=1 SHALL set occupancy to 0 on the next edge, irrespective of in_valid and out_ready.
REQ-023 An input offered while flush=1 SHALL be discarded.
REQ-024 in_ready SHALL be 1 while flush=1.
REQ-025 Payloads SHALL be passed bit-exact, with no width conversion and no arithmetic.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for clock, force occupancy=0, out_valid=0, out_ctrl=0 and out_data=0.
REQ-027 While reset=0, in_ready SHALL be 0.
REQ-028 An entry in flight when reset asserts SHALL be lost.
REQ-029 On the first rising edge after reset deasserts, the block SHALL be in EMPTY with in_ready=1.

Configuration
REQ-030 With macro PIPE_SKID_EN defined, the block SHALL provide a 2-entry skid buffer.
REQ-031 With PIPE_SKID_EN defined, in_ready SHALL be a register output equal to (occupancy < 2), giving full throughput with no ready path from out_ready to in_ready.
REQ-032 Without PIPE_SKID_EN, the block SHALL be a single entry with in_ready = !out_valid || out_ready (combinational pass-back), TWO SHALL be unreachable and occupancy[1] SHALL be 0.

Verification
REQ-033 Scenario (streaming): out_ready=1, in_data = 1,2,3,4 on consecutive cycles -> out_data = 1,2,3,4, each one cycle later, out_valid continuously 1.
REQ-034 Scenario (stall with PIPE_SKID_EN): A and B accepted while out_ready=0 -> occupancy=2 and in_ready=0; with out_ready=1, A then B are emitted with no loss or duplication.
REQ-035 Scenario (flush): occupancy=2, flush=1 and in_valid=1 with in_data=0x55 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, and 0x55 never appears at the output.
REQ-036 Scenario (asynchronous reset): reset driven 0 mid-cycle with occupancy=1 -> out_valid=0 and out_ctrl=0 before the next edge.
REQ-037 Scenario (bubble): in_ctrl=0xFF presented with in_valid=0 -> out_ctrl stays 0x00.
REQ-038 Scenario (simultaneous transfer in ONE): in and out transfer on the same edge -> occupancy stays 1 and out_data equals the new entry.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with optional 2-entry skid buffer (PIPE_SKID_EN)
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              push;
    logic              pop;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;

    assign out_valid = (state != EMPTY);
    assign occupancy = 2'(state);
    // Bubbles present zero control so no write enable can leak downstream.
    assign out_ctrl  = out_valid ? head_ctrl : '0;
    assign out_data  = head_data;
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & in_ready & ~flush;

`ifdef PIPE_SKID_EN
    logic [CTRL_W-1:0] tail_ctrl;
    logic [DATA_W-1:0] tail_data;
    logic              ready_q;

    assign in_ready = reset & (ready_q | flush);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_nxt != TWO);
        end
    end
`else
    assign in_ready = reset & (~out_valid | out_ready | flush);
`endif

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) state_nxt = ONE;
                ONE: begin
`ifdef PIPE_SKID_EN
                    if (push && !pop) state_nxt = TWO;
                    else
`endif
                    if (!push && pop) state_nxt = EMPTY;
                end
                TWO:     if (pop) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Data moves are gated by flush so out_data holds while the stage is emptied.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_ctrl <= '0;
            head_data <= '0;
`ifdef PIPE_SKID_EN
            tail_ctrl <= '0;
            tail_data <= '0;
`endif
        end else if (!flush) begin
            if ((state == EMPTY && push) || (state == ONE && push && pop)) begin
                head_ctrl <= in_ctrl;
                head_data <= in_data;
            end
`ifdef PIPE_SKID_EN
            if (state == TWO && pop) begin
                head_ctrl <= tail_ctrl;
                head_data <= tail_data;
            end
            if (state == ONE && push && !pop) begin
                tail_ctrl <= in_ctrl;
                tail_data <= in_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = 8'h00; in_data = 32'h0;
        #2;
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_octrl", 32'(out_ctrl), 0);
        chk("rst_odata", out_data, 0);
        chk("rst_iready", 32'(in_ready), 0);
        step();
        reset = 1'b1;
        #1;
        chk("post_rst_iready", 32'(in_ready), 1);

        // Streaming 1..4 with out_ready high; also in+out on the same edge in ONE
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i); in_ctrl = 8'(8'h10 + i);
            step();
            chk("stream_data", out_data, 32'(i));
            chk("stream_ctrl", 32'(out_ctrl), 32'(8'h10 + i));
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_occ", 32'(occupancy), 1);
        end
        in_valid = 1'b0;
        step();
        chk("drain_occ", 32'(occupancy), 0);
        chk("drain_ovalid", 32'(out_valid), 0);
        chk("drain_octrl", 32'(out_ctrl), 0);
        chk("drain_hold_data", out_data, 4);

        // Bubble: control offered without valid never reaches the output
        in_ctrl = 8'hFF; in_data = 32'hDEAD;
        step();
        chk("bubble_octrl", 32'(out_ctrl), 0);
        chk("bubble_occ", 32'(occupancy), 0);

        // Stall: head stays stable while out_ready is low
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'h21;
        step();
        in_valid = 1'b0; in_data = 32'h0; in_ctrl = 8'h00;
        chk("stall_occ", 32'(occupancy), 1);
        step();
        chk("stall_data", out_data, 32'hA);
        chk("stall_ctrl", 32'(out_ctrl), 32'h21);
        chk("stall_iready", 32'(in_ready), 32'(SKID));
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hB; in_ctrl = 8'h22;
        #1;
        chk("unstall_iready", 32'(in_ready), 1);
        step();
        chk("swap_occ", 32'(occupancy), 1);
        chk("swap_data", out_data, 32'hB);
        in_valid = 1'b0;
        step();
        chk("swap_drain_occ", 32'(occupancy), 0);

        // Flush with an input offered: input dropped, stage empty
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h33; in_ctrl = 8'h03;
        step();
        chk("fl_fill_occ", 32'(occupancy), 1);
        flush = 1'b1; in_data = 32'h55; in_ctrl = 8'h5F;
        #1;
        chk("fl_iready", 32'(in_ready), 1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ", 32'(occupancy), 0);
        chk("fl_ovalid", 32'(out_valid), 0);
        chk("fl_octrl", 32'(out_ctrl), 0);
        chk("fl_odata", out_data, 32'h33);
        step();
        chk("fl_after_ovalid", 32'(out_valid), 0);

        // Asynchronous reset mid-cycle drops the held entry
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h07;
        step();
        in_valid = 1'b0;
        chk("ar_occ_pre", 32'(occupancy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_ovalid", 32'(out_valid), 0);
        chk("ar_octrl", 32'(out_ctrl), 0);
        chk("ar_odata", out_data, 0);
        chk("ar_occ", 32'(occupancy), 0);
        chk("ar_iready", 32'(in_ready), 0);
        step();
        reset = 1'b1;
        step();
        chk("ar_lost_occ", 32'(occupancy), 0);
        chk("ar_iready_back", 32'(in_ready), 1);

`ifdef PIPE_SKID_EN
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA1; in_ctrl = 8'h31;
        step();
        in_data = 32'hB2; in_ctrl = 8'h32;
        step();
        in_valid = 1'b0;
        chk("skid_occ2", 32'(occupancy), 2);
        chk("skid_iready0", 32'(in_ready), 0);
        chk("skid_headA", out_data, 32'hA1);
        out_ready = 1'b1;
        step();
        chk("skid_headB", out_data, 32'hB2);
        chk("skid_ctrlB", 32'(out_ctrl), 32'h32);
        chk("skid_occ1", 32'(occupancy), 1);
        chk("skid_iready1", 32'(in_ready), 1);
        step();
        chk("skid_occ0", 32'(occupancy), 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hC3; in_ctrl = 8'h33;
        step();
        in_data = 32'hD4; in_ctrl = 8'h34;
        step();
        chk("skid_fl_occ2", 32'(occupancy), 2);
        flush = 1'b1; in_data = 32'h55; in_ctrl = 8'h5F;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("skid_fl_occ", 32'(occupancy), 0);
        chk("skid_fl_ovalid", 32'(out_valid), 0);
        chk("skid_fl_octrl", 32'(out_ctrl), 0);
        chk("skid_fl_odata", out_data, 32'hC3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
